bec_ladder_sched: RTL and testbench

//  Key-bit scheduler and handshake controller for the sm_bec_v3 binary-Edwards ladder core.
//  - Holds the scalar key and presents it MSB-first on core_ki, one bit per core_next_key request.
//  - Gates core_enable and detects completion and protocol errors.
//  - Sits between the Wishbone/LA register bank and bec_core; replaces direct register drive of enable/ki.

---
 rtl/bec_pkg.sv | 19 +
 rtl/bec_key_shreg.sv | 40 ++++
 rtl/bec_ladder_sched.sv | 140 ++++++++++++++
 tb/tb_bec_ladder_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared definitions for the binary-Edwards ladder key scheduler.
// Contains the default key width, the scheduler FSM states and the error codes.
package bec_pkg;

  localparam int KEY_W_DEF = 163;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_EARLY = 2'd1;
  localparam logic [1:0] ERR_EXTRA = 2'd2;
  localparam logic [1:0] ERR_WDOG  = 2'd3;

endpackage

// File: rtl/bec_key_shreg.sv
// Key shift register: parallel load, MSB-first shift-out with zero fill.
// When load and shift arrive together, the load wins.
module bec_key_shreg
  import bec_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             shift,
  output logic             msb
);

  logic [KEY_W-1:0] sr_q, sr_d;

  // NOTE: sr_d gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = key_in;
    end else if (shift) begin
      sr_d = {sr_q[KEY_W-2:0], 1'b0};
    end
  end

  // NOTE: this register is reset on purpose. A secret key must not survive a reset, so it has to be reloaded afterwards.
  // NOTE: state updates use <= so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[KEY_W-1];

endmodule

// File: rtl/bec_ladder_sched.sv
// Key-bit scheduler and handshake controller for the sm_bec_v3 ladder core.
// Optional watchdog is enabled by defining BEC_SCHED_WDOG_EN.
module bec_ladder_sched
  import bec_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] bit_idx,
  output logic             core_enable,
  output logic             core_ki,
  input  logic             core_next_key,
  input  logic             core_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             done_q, done_d;
  logic             core_done_q;
  logic             active, done_edge, load_en, shift_en, wdog_hit, key_msb;

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_edge = core_done & ~core_done_q;
  assign load_en   = key_load & ~active;
  assign shift_en  = (state_q == S_RUN) & core_next_key;

  bec_key_shreg #(.KEY_W(KEY_W)) u_key_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_en),
    .key_in (key_in),
    .shift  (shift_en),
    .msb    (key_msb)
  );

`ifdef BEC_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Any sign of core progress restarts the timeout window.
  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (!active || core_next_key || done_edge) begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_hit = active && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_RUN;
          bit_idx_d  = CNT_W'(KEY_W);
          err_code_d = ERR_NONE;
        end
      end
      S_RUN: begin
        // bit_idx is never zero here, so any completion edge is premature.
        if (done_edge) begin
          state_d    = S_ERR;
          err_code_d = ERR_EARLY;
        end else if (core_next_key) begin
          bit_idx_d = bit_idx_q - 1'b1;
          if (bit_idx_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (wdog_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_WDOG;
        end
      end
      S_DRAIN: begin
        if (core_next_key) begin
          state_d    = S_ERR;
          err_code_d = ERR_EXTRA;
        end else if (done_edge) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (wdog_hit) begin
          state_d    = S_ERR;
          err_code_d = ERR_WDOG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      core_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      core_done_q <= core_done;
    end
  end

  assign busy        = active;
  assign core_enable = active;
  assign core_ki     = active & key_msb;
  assign done        = done_q;
  assign err         = (state_q == S_ERR);
  assign err_code    = err_code_q;
  assign bit_idx     = bit_idx_q;

endmodule

// File: tb/tb_bec_ladder_sched.sv
// Directed self-checking bench for bec_ladder_sched with a key-bit scoreboard.
// Run with and without BEC_SCHED_WDOG_EN; the stall step adapts to the build.
module tb_bec_ladder_sched;

  localparam int KEY_W       = 163;
  localparam int CNT_W       = 8;
  localparam int WDOG_CYCLES = 64;

  logic             clk;
  logic             rst_n;
  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] bit_idx;
  logic             core_enable;
  logic             core_ki;
  logic             core_next_key;
  logic             core_done;

  int errors = 0;
  int checks = 0;
  int idx_model = 0;
  bit exp_q[$];

  bec_ladder_sched #(
    .KEY_W       (KEY_W),
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .key_load      (key_load),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .bit_idx       (bit_idx),
    .core_enable   (core_enable),
    .core_ki       (core_ki),
    .core_next_key (core_next_key),
    .core_done     (core_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] k;
    for (int i = 0; i < KEY_W; i++) k[i] = 1'($urandom_range(0, 1));
    return k;
  endfunction

  task automatic push_key(input logic [KEY_W-1:0] k);
    exp_q.delete();
    for (int i = KEY_W - 1; i >= 0; i--) exp_q.push_back(k[i]);
  endtask

  task automatic begin_run(input logic [KEY_W-1:0] k, input bit same_cycle);
    key_in   = k;
    key_load = 1'b1;
    start    = same_cycle;
    push_key(k);
    tick();
    key_load = 1'b0;
    if (!same_cycle) begin
      start = 1'b1;
      tick();
    end
    start     = 1'b0;
    idx_model = KEY_W;
    check("start_busy", busy, 1);
    check("start_enable", core_enable, 1);
    check("start_bit_idx", bit_idx, KEY_W);
    check("start_err", err, 0);
    check("start_err_code", err_code, 0);
  endtask

  // Core model: one next_key pulse every 5 cycles, checking ki against the scoreboard.
  task automatic consume(input int n);
    logic exp_bit;
    for (int i = 0; i < n; i++) begin
      repeat (4) tick();
      exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check("core_ki", core_ki, exp_bit);
      check("run_bit_idx", bit_idx, idx_model);
      core_next_key = 1'b1;
      tick();
      core_next_key = 1'b0;
      idx_model--;
    end
  endtask

  task automatic finish_ok();
    check("drain_bit_idx", bit_idx, 0);
    check("drain_busy", busy, 1);
    check("drain_enable", core_enable, 1);
    repeat (3) tick();
    check("drain_no_done", done, 0);
    core_done = 1'b1;
    tick();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_enable", core_enable, 0);
    check("done_err", err, 0);
    tick();
    check("done_single", done, 0);
    core_done = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_enable"}, core_enable, 0);
    check({tag, "_ki"}, core_ki, 0);
    check({tag, "_bit_idx"}, bit_idx, 0);
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    rst_n         = 1'b0;
    key_in        = '0;
    key_load      = 1'b0;
    start         = 1'b0;
    core_next_key = 1'b0;
    core_done     = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // MSB and LSB set: ki runs 1, then 161 zeros, then 1.
    k = '0;
    k[KEY_W-1] = 1'b1;
    k[0] = 1'b1;
    begin_run(k, 1'b0);
    consume(KEY_W);
    finish_ok();

    // Premature completion after 100 bits; load and start share a cycle.
    begin_run(rand_key(), 1'b1);
    consume(100);
    core_done = 1'b1;
    tick();
    check("early_err", err, 1);
    check("early_err_code", err_code, 1);
    check("early_enable", core_enable, 0);
    check("early_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("early_no_done", done, 0);
      tick();
    end
    core_done = 1'b0;
    exp_q.delete();
    tick();

    // Extra next_key in DRAIN, coinciding with core_done: the error wins.
    begin_run(rand_key(), 1'b0);
    consume(KEY_W);
    check("extra_pre_bit_idx", bit_idx, 0);
    core_next_key = 1'b1;
    core_done     = 1'b1;
    tick();
    core_next_key = 1'b0;
    check("extra_err", err, 1);
    check("extra_err_code", err_code, 2);
    check("extra_no_done", done, 0);
    check("extra_enable", core_enable, 0);
    core_done = 1'b0;
    tick();

    // key_load and start during RUN are ignored.
    k = rand_key();
    begin_run(k, 1'b0);
    consume(20);
    key_in   = ~k;
    key_load = 1'b1;
    start    = 1'b1;
    tick();
    key_load = 1'b0;
    start    = 1'b0;
    check("ignore_busy", busy, 1);
    check("ignore_bit_idx", bit_idx, KEY_W - 20);
    check("ignore_err", err, 0);
    consume(KEY_W - 20);
    finish_ok();
    core_next_key = 1'b1;
    tick();
    core_next_key = 1'b0;
    check("idle_next_key_err", err, 0);
    check("idle_next_key_busy", busy, 0);

    // Reset mid-run at bit_idx 50 clears everything, including the key.
    begin_run(rand_key(), 1'b0);
    consume(KEY_W - 50);
    check("midrun_bit_idx", bit_idx, 50);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start     = 1'b0;
    idx_model = KEY_W;
    push_key('0);
    consume(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reload and full run after reset.
    begin_run(rand_key(), 1'b0);
    consume(KEY_W);
    finish_ok();

    // Core stalls after 10 bits.
    begin_run(rand_key(), 1'b0);
    consume(10);
`ifdef BEC_SCHED_WDOG_EN
    repeat (WDOG_CYCLES - 1) tick();
    check("wdog_pre_busy", busy, 1);
    check("wdog_pre_err", err, 0);
    tick();
    check("wdog_err", err, 1);
    check("wdog_err_code", err_code, 3);
    check("wdog_enable", core_enable, 0);
`else
    repeat (300) tick();
    check("stall_busy", busy, 1);
    check("stall_err", err, 0);
    check("stall_enable", core_enable, 1);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
